// File: rtl/pixel_server.sv
// pixel_server: pixel store answering a four-phase request/avail handshake after a fixed read latency.
// Define PIXEL_SERVER_STATS_EN to add saturating req_count / oor_count outputs.
module pixel_server #(
    parameter int          IMG_PIXELS   = 4096,
    parameter int          READ_LATENCY = 4,
    parameter logic [31:0] OOR_VALUE    = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic [31:0] addr_pixel,
    input  logic        request_pixel,
    output logic [31:0] pixel,
    output logic        pixel_avail,
    input  logic        img_wr_en,
    input  logic [31:0] img_wr_addr,
    input  logic [31:0] img_wr_data,
`ifdef PIXEL_SERVER_STATS_EN
    output logic [31:0] req_count,
    output logic [31:0] oor_count,
`endif
    output logic        busy
);
    localparam int AW = IMG_PIXELS > 1 ? $clog2(IMG_PIXELS) : 1;
    localparam int CW = $clog2(READ_LATENCY + 1);
    localparam logic [31:0] LIMIT = 32'(IMG_PIXELS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_RELEASE} state_t;

    state_t        r_state;
    logic [31:0]   r_addr;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_mem [IMG_PIXELS];

    logic          w_wr_ok;
    logic          w_rd_ok;
    logic          w_final;
    logic [31:0]   w_resp;

    assign w_wr_ok = img_wr_en && img_wr_addr < LIMIT;
    assign w_rd_ok = r_addr < LIMIT;
    assign w_final = r_state == S_WAIT && request_pixel && r_cnt == '0;
    // a write landing on the response edge must win over the stale store word
    assign w_resp  = !w_rd_ok ? OOR_VALUE :
                     (img_wr_en && img_wr_addr == r_addr) ? img_wr_data : r_mem[r_addr[AW-1:0]];

    always_ff @(posedge clk)
        if (w_wr_ok)
            r_mem[img_wr_addr[AW-1:0]] <= img_wr_data;

    always_ff @(posedge clk or negedge res_n)
        if (!res_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_cnt       <= '0;
            pixel       <= '0;
            pixel_avail <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:
                    if (request_pixel) begin
                        r_addr  <= addr_pixel;
                        r_cnt   <= CW'(READ_LATENCY);
                        r_state <= S_WAIT;
                        busy    <= 1'b1;
                    end
                S_WAIT:
                    if (!request_pixel) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        pixel       <= w_resp;
                        pixel_avail <= 1'b1;
                        r_state     <= S_RESP;
                    end
                S_RESP:
                    if (!request_pixel) begin
                        pixel_avail <= 1'b0;
                        r_state     <= S_RELEASE;
                    end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end

`ifdef PIXEL_SERVER_STATS_EN
    logic w_accept;
    assign w_accept = r_state == S_IDLE && request_pixel;

    always_ff @(posedge clk or negedge res_n)
        if (!res_n) begin
            req_count <= '0;
            oor_count <= '0;
        end else begin
            if (w_accept && req_count != '1)
                req_count <= req_count + 32'd1;
            if (w_final && !w_rd_ok && oor_count != '1)
                oor_count <= oor_count + 32'd1;
        end
`endif
endmodule

// File: tb/tb_pixel_server.sv
// tb_pixel_server: directed transactions against a timeline/store model of the pixel handshake.
module tb_pixel_server;
    localparam int L = 4;
    localparam int N = 4096;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic [31:0] addr_pixel = '0;
    logic        request_pixel = 1'b0;
    logic [31:0] pixel;
    logic        pixel_avail;
    logic        img_wr_en = 1'b0;
    logic [31:0] img_wr_addr = '0;
    logic [31:0] img_wr_data = '0;
    logic        busy;
`ifdef PIXEL_SERVER_STATS_EN
    logic [31:0] req_count, oor_count;
`endif

    pixel_server #(.IMG_PIXELS(N), .READ_LATENCY(L), .OOR_VALUE(32'hDEAD_BEEF)) dut (
        .clk(clk), .res_n(res_n), .addr_pixel(addr_pixel), .request_pixel(request_pixel),
        .pixel(pixel), .pixel_avail(pixel_avail), .img_wr_en(img_wr_en),
        .img_wr_addr(img_wr_addr), .img_wr_data(img_wr_data),
`ifdef PIXEL_SERVER_STATS_EN
        .req_count(req_count), .oor_count(oor_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [int];
    logic        chk_en = 1'b0;
    logic        exp_avail = 1'b0;
    logic        exp_busy = 1'b0;
    logic [31:0] exp_pixel = '0;
    int          n_req = 0;
    int          n_oor = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_pix(input logic [31:0] i);
        if (i >= 32'(N))
            return 32'hDEAD_BEEF;
        return mdl[int'(i)];
    endfunction

    always @(negedge clk)
        if (chk_en) begin
            check("avail", {31'd0, pixel_avail}, {31'd0, exp_avail});
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("pixel", pixel, exp_pixel);
`ifdef PIXEL_SERVER_STATS_EN
            check("req_count", req_count, 32'(n_req));
            check("oor_count", oor_count, 32'(n_oor));
`endif
        end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] idx, input logic [31:0] data);
        img_wr_en = 1'b1;
        img_wr_addr = idx;
        img_wr_data = data;
        if (idx < 32'(N))
            mdl[int'(idx)] = data;
        step();
        img_wr_en = 1'b0;
    endtask

    // request sampled at edge k; response visible after edge k+L+1
    task automatic txn(input logic [31:0] idx, input int hold, input bit late_wr, input logic [31:0] late_data);
        addr_pixel = idx;
        request_pixel = 1'b1;
        step();
        exp_busy = 1'b1;
        n_req++;
        addr_pixel = ~idx;
        repeat (L) step();
        if (late_wr) begin
            img_wr_en = 1'b1;
            img_wr_addr = idx;
            img_wr_data = late_data;
            if (idx < 32'(N))
                mdl[int'(idx)] = late_data;
        end
        step();
        img_wr_en = 1'b0;
        exp_avail = 1'b1;
        exp_pixel = ref_pix(idx);
        if (idx >= 32'(N))
            n_oor++;
        repeat (hold) step();
        request_pixel = 1'b0;
        step();
        exp_avail = 1'b0;
        step();
        exp_busy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        #12;
        check("rst_pixel", pixel, 32'h0);
        check("rst_avail", {31'd0, pixel_avail}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        step();
        res_n = 1'b1;
        chk_en = 1'b1;
        step();

        // T1: basic read, then a literal latency probe
        wr(5, 32'h00AB_CDEF);
        txn(5, 3, 1'b0, '0);
        check("t1_pixel", pixel, 32'h00AB_CDEF);
        chk_en = 1'b0;
        addr_pixel = 5;
        request_pixel = 1'b1;
        step();
        n_req++;
        lat = 0;
        while (!pixel_avail && lat < 20) begin
            step();
            lat++;
        end
        check("t1_latency", 32'(lat), 32'd5);
        check("t1_probe_pixel", pixel, 32'h00AB_CDEF);
        request_pixel = 1'b0;
        step();
        check("t1_drop", {31'd0, pixel_avail}, 32'h0);
        step();
        chk_en = 1'b1;

        // T2: out of range, including indices that would alias if truncated
        txn(4096, 1, 1'b0, '0);
        check("t2_oor", pixel, 32'hDEAD_BEEF);
        txn(32'h0000_1005, 0, 1'b0, '0);
        check("t2_oor_alias", pixel, 32'hDEAD_BEEF);
        txn(32'hFFFF_FFFF, 0, 1'b0, '0);
        txn(4095, 0, 1'b1, 32'h0FFF_0FFF);
        check("t2_last_idx", pixel, 32'h0FFF_0FFF);

        // T3: abort in the second WAIT cycle, then a normal request
        wr(7, 32'h0000_0077);
        addr_pixel = 7;
        request_pixel = 1'b1;
        step();
        exp_busy = 1'b1;
        n_req++;
        step();
        request_pixel = 1'b0;
        step();
        exp_busy = 1'b0;
        step();
        txn(7, 0, 1'b0, '0);
        check("t3_pixel", pixel, 32'h0000_0077);

        // a request raised during RELEASE is taken only from IDLE; dropping it in WAIT aborts
        addr_pixel = 5;
        request_pixel = 1'b1;
        step();
        exp_busy = 1'b1;
        n_req++;
        repeat (L) step();
        step();
        exp_avail = 1'b1;
        exp_pixel = ref_pix(5);
        request_pixel = 1'b0;
        step();
        exp_avail = 1'b0;
        addr_pixel = 7;
        request_pixel = 1'b1;
        step();
        exp_busy = 1'b0;
        step();
        exp_busy = 1'b1;
        n_req++;
        request_pixel = 1'b0;
        step();
        exp_busy = 1'b0;
        step();

        // T4: write-first on the final WAIT edge; out-of-range writes are dropped
        wr(9, 32'h1);
        txn(9, 1, 1'b1, 32'h2);
        check("t4_collision", pixel, 32'h2);
        wr(32'(N + 9), 32'h0000_0BAD);
        txn(9, 0, 1'b0, '0);
        check("t4_oor_write", pixel, 32'h2);

        // T5: asynchronous reset while in RESP
        addr_pixel = 9;
        request_pixel = 1'b1;
        step();
        exp_busy = 1'b1;
        n_req++;
        repeat (L) step();
        step();
        exp_avail = 1'b1;
        exp_pixel = 32'h2;
        #2;
        res_n = 1'b0;
        exp_avail = 1'b0;
        exp_busy = 1'b0;
        exp_pixel = '0;
        n_req = 0;
        n_oor = 0;
        #1;
        check("t5_avail", {31'd0, pixel_avail}, 32'h0);
        check("t5_pixel", pixel, 32'h0);
        check("t5_busy", {31'd0, busy}, 32'h0);
        request_pixel = 1'b0;
        step();
        res_n = 1'b1;
        step();
        txn(9, 0, 1'b0, '0);
        check("t5_after", pixel, 32'h2);

        // T6: 100 back-to-back requests, each dropped as soon as avail is seen
        for (int i = 0; i < 100; i++)
            wr(32'(200 + i), 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000);
        for (int i = 0; i < 100; i++)
            txn(32'(200 + (i * 37) % 100), 0, 1'b0, '0);
        check("t6_reqs", 32'(n_req), 32'd101);
`ifdef PIXEL_SERVER_STATS_EN
        check("t6_req_count", req_count, 32'd101);
        check("t6_oor_count", oor_count, 32'd0);
`endif
        step();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
